// File: rtl/muldiv_seq_if.sv
// muldiv_seq request/result bundle.
// master = EX pipeline side, slave = mul/div unit.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit with HI/LO.
// Works on magnitudes; signs are applied in FIXUP.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] a_orig;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             take;
  logic             launch;
  logic             mt_hi;
  logic             mt_lo;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_step;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    div_step;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Request decode and operand magnitudes
  always_comb begin
    take   = (state == IDLE) && bus.start && !bus.flush;
    launch = take && !bus.op[2];
    mt_hi  = take && (bus.op == 3'b100);
    mt_lo  = take && (bus.op == 3'b101);
    sa     = bus.op[0] && bus.a[WIDTH-1];
    sb     = bus.op[0] && bus.b[WIDTH-1];
    abs_a  = sa ? -bus.a : bus.a;
    abs_b  = sb ? -bus.b : bus.b;
  end

  // One shift-add and one restoring shift-subtract step
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:WIDTH]}
             + {1'b0, (acc[0] ? ma : '0)};
    mul_step = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    diff     = rem_sh - {1'b0, mb};
    if (diff[WIDTH])
      div_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction and divide-by-zero override
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    res_hi = prod[W2-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    unique case (1'b1)
      is_div && b_zero: begin
        res_hi = a_orig;
        res_lo = '1;
      end
      is_div && !b_zero: begin
        res_hi = rem;
        res_lo = quo;
      end
      !is_div: begin
        res_hi = prod[W2-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (launch) state_nx = CALC;
      CALC: begin
        if (bus.flush)     state_nx = IDLE;
        else if (cnt == 0) state_nx = FIXUP;
      end
      FIXUP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      ma     <= '0;
      mb     <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        ma     <= abs_a;
        mb     <= bus.op[1] ? abs_b : abs_a;
        acc    <= {{WIDTH{1'b0}},
                   (bus.op[1] ? abs_a : abs_b)};
        a_orig <= bus.a;
        is_div <= bus.op[1];
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        b_zero <= (bus.b == '0);
        cnt    <= CW'(WIDTH - 1);
        dz_q   <= 1'b0;
      end
      if (mt_hi) hi_q <= bus.a;
      if (mt_lo) lo_q <= bus.a;
      if (state == CALC && !bus.flush) begin
        acc <= is_div ? div_step : mul_step;
        cnt <= cnt - 1'b1;
      end
      if (state == FIXUP && !bus.flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
        dz_q   <= is_div && b_zero;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: behavioural HI/LO model,
// per-cycle compare, directed and random ops.
module tb_muldiv_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dz;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] h,
    output logic [31:0] l,
    output logic        dz);
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = '0;
    l  = '0;
    dz = 1'b0;
    case (op)
      3'd0: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      3'd1: begin
        q = sa * sb;
        h = q[63:32];
        l = q[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          h  = a;
          l  = '1;
          dz = 1'b1;
        end else if (op == 3'd2) begin
          l = a / b;
          h = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Architectural model: one accepted mul/div completes W+1 edges later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
      m_dz   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (bus.flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi   = r_hi;
            m_lo   = r_lo;
            m_dz   = r_dz;
            m_done = 1'b1;
          end
        end
      end else if (bus.start && !bus.flush) begin
        if (!bus.op[2]) begin
          ref_op(bus.op, bus.a, bus.b, r_hi, r_lo, r_dz);
          m_left = W + 1;
          m_dz   = 1'b0;
        end else if (bus.op == 3'd4) m_hi = bus.a;
        else if (bus.op == 3'd5)     m_lo = bus.a;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 64'(bus.busy), 64'(m_left > 0));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("div_zero", 64'(bus.div_zero), 64'(m_dz));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(output int nb, output bit seen);
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) nb++;
    end
  endtask

  task automatic run(input string name,
                     input logic [2:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] eh,
                     input logic [31:0] el,
                     input logic edz);
    int nb;
    bit seen;
    issue(o, x, y);
    wait_done(nb, seen);
    chk({name, "_done"}, 64'(seen), 64'd1);
    chk({name, "_busycyc"}, 64'(nb), 64'd33);
    chk({name, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({name, "_lo"}, 64'(bus.lo), 64'(el));
    chk({name, "_dz"}, 64'(bus.div_zero), 64'(edz));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] th, tl;
    logic        tz;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    ref_op(3'd1, 32'hFFFF_FFFD, 32'd7, th, tl, tz);
    chk("ref_mult", {th, tl}, 64'hFFFF_FFFF_FFFF_FFEB);
    ref_op(3'd3, 32'hFFFF_FFF9, 32'd2, th, tl, tz);
    chk("ref_div", {th, tl}, 64'hFFFF_FFFF_FFFF_FFFD);
    ref_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, th, tl, tz);
    chk("ref_divovf", {th, tl}, 64'h0000_0000_8000_0000);
    ref_op(3'd1, 32'h8000_0000, 32'h8000_0000, th, tl, tz);
    chk("ref_minmin", {th, tl}, 64'h4000_0000_0000_0000);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    run("mult", 3'd1, 32'hFFFF_FFFD, 32'd7,
        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run("multu", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run("div", 3'd3, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("divu", 3'd2, 32'd100, 32'd7,
        32'd2, 32'd14, 1'b0);
    run("div0", 3'd2, 32'h1234, 32'd0,
        32'h1234, 32'hFFFF_FFFF, 1'b1);
    run("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0, 32'h8000_0000, 1'b0);
    run("minmin", 3'd1, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 32'h0, 1'b0);

    issue(3'd1, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    begin
      bit sawd;
      sawd = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done) sawd = 1'b1;
      end
      chk("flush_nodone", 64'(sawd), 64'd0);
    end
    chk("flush_hilo", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("sflush_hi", 64'(bus.hi), 64'h4000_0000);
    chk("sflush_busy", 64'(bus.busy), 64'd0);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.op    = 3'd5;
    bus.a     = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("mthi", 64'(bus.hi), 64'hA5A5_A5A5);
    chk("mt_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("mtlo", 64'(bus.lo), 64'h5A5A_5A5A);
    chk("mt_hi_keep", 64'(bus.hi), 64'hA5A5_A5A5);

    issue(3'd0, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a     = 32'h1111_1111;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("busystart", {bus.hi, bus.lo}, 64'd12);

    issue(3'd1, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_out",
        64'({bus.done, bus.div_zero, bus.hi, bus.lo}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int n = 0; n < 200; n++) begin
      logic [2:0] o;
      int         mode;
      o    = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      issue(o, pick(), pick());
      if (mode == 0) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
      end else if (mode == 1) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'($urandom_range(0, 7));
        @(posedge clk); #1 bus.start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
